// File: rtl/wb_openram_arbiter.sv
// wb_openram_arbiter: round-robin multi-port Wishbone front-end for one OpenRAM RW port (port 0).
// Optional macro WB_OPENRAM_ERR_EN adds wbs_err_o, flagging writes issued by read-only ports.

module wb_openram_arbiter #(
    parameter int                      NUM_PORTS   = 2,
    parameter logic [32*NUM_PORTS-1:0] BASE_ADDRS  = {NUM_PORTS{32'h3000_0000}},
    parameter int                      ADDR_WIDTH  = 8,
    parameter int                      RAM_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_PORTS-1:0]      writable_i,
    input  logic [NUM_PORTS-1:0]      wbs_stb_i,
    input  logic [NUM_PORTS-1:0]      wbs_cyc_i,
    input  logic [NUM_PORTS-1:0]      wbs_we_i,
    input  logic [4*NUM_PORTS-1:0]    wbs_sel_i,
    input  logic [32*NUM_PORTS-1:0]   wbs_dat_i,
    input  logic [32*NUM_PORTS-1:0]   wbs_adr_i,
    output logic [NUM_PORTS-1:0]      wbs_ack_o,
    output logic [32*NUM_PORTS-1:0]   wbs_dat_o,
`ifdef WB_OPENRAM_ERR_EN
    output logic [NUM_PORTS-1:0]      wbs_err_o,
`endif
    output logic                      ram_clk0,
    output logic                      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [31:0]               ram_din0,
    input  logic [31:0]               ram_dout0
);

    localparam int IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TAG_LSB = ADDR_WIDTH + 2;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic                   we_q, we_d;
    logic                   abort_q, abort_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [31:0]            dat_q [NUM_PORTS];
    logic [31:0]            dat_d [NUM_PORTS];
    logic                   csb_q, csb_d;
    logic                   web_q, web_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            din_q, din_d;
`ifdef WB_OPENRAM_ERR_EN
    logic                   drop_q, drop_d;
    logic [NUM_PORTS-1:0]   err_q, err_d;
`endif

    logic [NUM_PORTS-1:0]   hit_s;
    logic                   gnt_found_s;
    logic [IDX_W-1:0]       gnt_sel_s;
    logic                   gnt_we_s;
    logic                   gnt_ro_wr_s;
    logic                   abort_now_s;
    logic                   unused_s;

    // Only the tag bits above the RAM window take part in decode
    assign unused_s = ^wbs_adr_i;

    // Per-port base-address hit detection
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            hit_s[i] = wbs_cyc_i[i] & wbs_stb_i[i] &
                       (wbs_adr_i[32*i+TAG_LSB +: TAG_W] == BASE_ADDRS[32*i+TAG_LSB +: TAG_W]);
        end
    end

    // Round-robin search: first hit starting after the last granted port
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_sel_s   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!gnt_found_s && hit_s[IDX_W'((int'(ptr_q) + k) % NUM_PORTS)]) begin
                gnt_found_s = 1'b1;
                gnt_sel_s   = IDX_W'((int'(ptr_q) + k) % NUM_PORTS);
            end else begin
                gnt_sel_s   = gnt_sel_s;
            end
        end
    end

    assign gnt_we_s    = wbs_we_i[gnt_sel_s];
    assign gnt_ro_wr_s = gnt_we_s & ~writable_i[gnt_sel_s];
    assign abort_now_s = abort_q | ~wbs_cyc_i[gnt_q];

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        abort_d = abort_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        dat_d   = dat_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef WB_OPENRAM_ERR_EN
        drop_d  = drop_q;
        err_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found_s) begin
                    gnt_d   = gnt_sel_s;
                    ptr_d   = gnt_sel_s;
                    we_d    = gnt_we_s;
                    abort_d = 1'b0;
                    csb_d   = gnt_ro_wr_s;
                    web_d   = ~gnt_we_s;
                    wmask_d = wbs_sel_i[4*int'(gnt_sel_s) +: 4];
                    addr_d  = wbs_adr_i[32*int'(gnt_sel_s)+2 +: ADDR_WIDTH];
                    din_d   = wbs_dat_i[32*int'(gnt_sel_s) +: 32];
`ifdef WB_OPENRAM_ERR_EN
                    drop_d  = gnt_ro_wr_s;
`endif
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                csb_d = 1'b1;
                web_d = 1'b1;
                if (we_q) begin
                    if (abort_now_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACK;
`ifdef WB_OPENRAM_ERR_EN
                        if (drop_q) begin
                            err_d[gnt_q] = 1'b1;
                        end else begin
                            ack_d[gnt_q] = 1'b1;
                        end
`else
                        ack_d[gnt_q] = 1'b1;
`endif
                    end
                end else begin
                    abort_d = abort_now_s;
                    cnt_d   = 3'(RAM_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    dat_d[gnt_q] = ram_dout0;
                    if (abort_now_s) begin
                        state_d = S_IDLE;
                    end else begin
                        ack_d[gnt_q] = 1'b1;
                        state_d      = S_ACK;
                    end
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    abort_d = abort_now_s;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; rr pointer resets to last port so port 0 wins first
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= IDX_W'(NUM_PORTS - 1);
            gnt_q   <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= 3'd0;
            ack_q   <= '0;
            dat_q   <= '{default: 32'h0};
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'h0;
            addr_q  <= '0;
            din_q   <= 32'h0;
`ifdef WB_OPENRAM_ERR_EN
            drop_q  <= 1'b0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
`ifdef WB_OPENRAM_ERR_EN
            drop_q  <= drop_d;
            err_q   <= err_d;
`endif
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_dat
            assign wbs_dat_o[32*g +: 32] = dat_q[g];
        end
    endgenerate

    assign wbs_ack_o  = ack_q;
`ifdef WB_OPENRAM_ERR_EN
    assign wbs_err_o  = err_q;
`endif
    assign ram_clk0   = wb_clk_i;
    assign ram_csb0   = csb_q;
    assign ram_web0   = web_q;
    assign ram_wmask0 = wmask_q;
    assign ram_addr0  = addr_q;
    assign ram_din0   = din_q;

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// tb_wb_openram_arbiter: directed + randomized bench with a behavioural OpenRAM and a
// transaction-level memory model; honours WB_OPENRAM_ERR_EN when defined.

module tb_wb_openram_arbiter;

    localparam int          NP  = 2;
    localparam int          AW  = 8;
    localparam int          LAT = 3;
    localparam logic [63:0] BASES = {32'h3000_0000, 32'h3000_0000};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     writable = '1;
    logic [NP-1:0]     stb = '0, cyc = '0, we = '0;
    logic [4*NP-1:0]   sel = '0;
    logic [32*NP-1:0]  dat_i = '0, adr = '0;
    logic [NP-1:0]     ack;
    logic [32*NP-1:0]  dat_o;
    logic [NP-1:0]     err;
    logic              ram_clk, ram_csb, ram_web;
    logic [3:0]        ram_wmask;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_din, ram_dout;

    int                checks = 0;
    int                errors = 0;

    logic [31:0]       mem [256];
    logic [31:0]       ref_mem [256];
    logic [31:0]       pipe [LAT];
    logic              mem_init_done = 1'b0;

    always #5 clk = ~clk;

    wb_openram_arbiter #(
        .NUM_PORTS(NP), .BASE_ADDRS(BASES), .ADDR_WIDTH(AW), .RAM_LATENCY(LAT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .writable_i(writable),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
`ifdef WB_OPENRAM_ERR_EN
        .wbs_err_o(err),
`endif
        .ram_clk0(ram_clk), .ram_csb0(ram_csb), .ram_web0(ram_web), .ram_wmask0(ram_wmask),
        .ram_addr0(ram_addr), .ram_din0(ram_din), .ram_dout0(ram_dout)
    );

`ifndef WB_OPENRAM_ERR_EN
    assign err = '0;
`endif

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural OpenRAM port: read data appears LAT-1 cycles after the sampling edge
    always @(posedge ram_clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (!ram_csb && !ram_web) begin
            mem[ram_addr] <= merge(mem[ram_addr], ram_din, ram_wmask);
        end
        pipe[0] <= (!ram_csb && ram_web) ? mem[ram_addr] : 32'hBAD0_BAD0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_dout = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w;
        adr[32*p +: 32] = a; dat_i[32*p +: 32] = d; sel[4*p +: 4] = s;
    endtask

    task automatic drop(input int p);
        cyc[p] = 1'b0; stb[p] = 1'b0;
    endtask

    // One transaction on an otherwise idle bus; checks issue signals, latency, response, data
    task automatic single(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        int k; bit got; bit csb_extra; bit ro; logic [7:0] wa; int exp_lat;
        logic [NP-1:0] a_seen, e_seen, exp_ack, exp_err;
        ro = w && !writable[p];
        wa = a[9:2];
        exp_lat = w ? 2 : 2 + LAT;
        k = 0; got = 0; csb_extra = 0; a_seen = '0; e_seen = '0; rd = '0;
        req(p, w, a, d, s);
        while (!got && k < 30) begin
            tick();
            k++;
            if (k == 1) begin
                chk("issue_csb", {31'b0, ram_csb}, {31'b0, ro});
                if (!ro) begin
                    chk("issue_web", {31'b0, ram_web}, {31'b0, ~w});
                    chk("issue_addr", {24'b0, ram_addr}, {24'b0, wa});
                    if (w) begin
                        chk("issue_wmask", {28'b0, ram_wmask}, {28'b0, s});
                        chk("issue_din", ram_din, d);
                    end
                end
            end else if (!ram_csb) begin
                csb_extra = 1;
            end
            a_seen = ack; e_seen = err;
            if (a_seen != '0 || e_seen != '0) got = 1;
        end
        drop(p);
        chk("resp_seen", {31'b0, got}, 32'd1);
        chk("latency", 32'(k), 32'(exp_lat));
        exp_ack = NP'(1) << p;
        exp_err = '0;
`ifdef WB_OPENRAM_ERR_EN
        if (ro) begin exp_err = exp_ack; exp_ack = '0; end
`endif
        chk("ack_vec", 32'(a_seen), 32'(exp_ack));
        chk("err_vec", 32'(e_seen), 32'(exp_err));
        chk("csb_only_issue", {31'b0, csb_extra}, 32'd0);
        if (!w) begin
            rd = dat_o[32*p +: 32];
            chk("rdata", rd, ref_mem[wa]);
        end else if (!ro) begin
            ref_mem[wa] = merge(ref_mem[wa], d, s);
        end
        tick();
        chk("ack_one_cycle", 32'(ack | err), 32'd0);
    endtask

    logic        pw [NP];
    logic [31:0] pa [NP];
    logic [31:0] pd [NP];
    logic [3:0]  ps [NP];

    task automatic new_rand_req(input int p);
        pw[p] = 1'($urandom_range(0, 1));
        pa[p] = 32'h3000_0000 | (32'($urandom_range(0, 255)) << 2);
        pd[p] = $urandom;
        ps[p] = 4'($urandom_range(0, 15));
        req(p, pw[p], pa[p], pd[p], ps[p]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] rd;
        int n_ack, exp_port, pa_idx, budget;
        bit any_ack, any_csb;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        // Reset state
        tick(); tick(); tick();
        chk("rst_csb", {31'b0, ram_csb}, 32'd1);
        chk("rst_web", {31'b0, ram_web}, 32'd1);
        chk("rst_wmask", {28'b0, ram_wmask}, 32'd0);
        chk("rst_addr", {24'b0, ram_addr}, 32'd0);
        chk("rst_din", ram_din, 32'd0);
        chk("rst_ack", 32'(ack | err), 32'd0);
        chk("rst_dat0", dat_o[31:0], 32'd0);
        chk("rst_dat1", dat_o[63:32], 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic write / read / byte-masked write
        single(0, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, rd);
        single(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);
        chk("spec_rd1", rd, 32'hDEAD_BEEF);
        single(0, 1'b1, 32'h3000_0010, 32'h0000_AB00, 4'h2, rd);
        single(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);
        chk("spec_rd2", rd, 32'hDEAD_ABEF);

        // Top word of the window, read back through the other port; port 0 data holds
        single(0, 1'b1, 32'h3000_03FC, $urandom, 4'hF, rd);
        single(1, 1'b0, 32'h3000_03FC, 32'h0, 4'hF, rd);
        chk("dat_hold_p0", dat_o[31:0], 32'hDEAD_ABEF);

        // Addresses just outside the window are ignored
        req(0, 1'b0, 32'h3000_0400, 32'h0, 4'hF);
        req(1, 1'b1, 32'h2FFF_FFFC, 32'h1111_1111, 4'hF);
        any_ack = 0; any_csb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack != '0 || err != '0) any_ack = 1;
            if (!ram_csb) any_csb = 1;
        end
        drop(0); drop(1);
        chk("miss_no_ack", {31'b0, any_ack}, 32'd0);
        chk("miss_no_csb", {31'b0, any_csb}, 32'd0);
        tick();

        // Both ports requesting continuously: strict alternation starting with port 0
        new_rand_req(0);
        new_rand_req(1);
        n_ack = 0; exp_port = 0; budget = 0;
        while (n_ack < 10 && budget < 200) begin
            tick();
            budget++;
            if (ack != '0) begin
                chk("arb_onehot", 32'($countones(ack)), 32'd1);
                pa_idx = ack[1] ? 1 : 0;
                chk("arb_order", 32'(pa_idx), 32'(exp_port));
                if (!pw[pa_idx]) begin
                    chk("arb_rdata", dat_o[32*pa_idx +: 32], ref_mem[pa[pa_idx][9:2]]);
                end else begin
                    ref_mem[pa[pa_idx][9:2]] = merge(ref_mem[pa[pa_idx][9:2]], pd[pa_idx], ps[pa_idx]);
                end
                exp_port = 1 - pa_idx;
                n_ack++;
                if (n_ack < 10) new_rand_req(pa_idx);
                else begin drop(0); drop(1); end
            end
        end
        drop(0); drop(1);
        chk("arb_count", 32'(n_ack), 32'd10);
        tick(); tick(); tick();

        // Write from a read-only port never reaches the RAM
        writable = 2'b01;
        single(1, 1'b1, 32'h3000_0020, 32'h1234_5678, 4'hF, rd);
        single(0, 1'b0, 32'h3000_0020, 32'h0, 4'hF, rd);
        writable = 2'b11;

        // Granted port drops cyc during the read wait: no ack, next read served
        req(1, 1'b0, 32'h3000_0030, 32'h0, 4'hF);
        any_ack = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 3) drop(1);
            if (ack != '0 || err != '0) any_ack = 1;
        end
        chk("abort_no_ack", {31'b0, any_ack}, 32'd0);
        single(0, 1'b0, 32'h3000_0030, 32'h0, 4'hF, rd);

        // Asynchronous reset in the middle of a read
        req(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_csb", {31'b0, ram_csb}, 32'd1);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_dat0", dat_o[31:0], 32'd0);
        chk("mid_rst_dat1", dat_o[63:32], 32'd0);
        drop(0);
        tick();
        rst_n = 1'b1;
        any_ack = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack != '0 || err != '0) any_ack = 1;
        end
        chk("post_rst_no_ack", {31'b0, any_ack}, 32'd0);
        single(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
